// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: control in, imem preload port, IF outputs.
// The fetch stage takes the slave modport; the driver of start/stall/branch/imem takes master.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              if_valid;
  logic              if_wr;
  logic [31:0]       pc;
  logic              halted;
  logic [15:0]       fetch_cnt;

  modport master (
    output start, stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    input  if_instr, if_pc, if_valid, if_wr, pc, halted, fetch_cnt
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    output if_instr, if_pc, if_valid, if_wr, pc, halted, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, preloadable imem, one registered instruction per cycle.
// Stalls on hazards, redirects on taken branches, stops on the halt word.
module fetch_stage #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] if_pc_q;
  logic        valid_q;
  logic        halted_q;
  logic [15:0] cnt_q;

  logic [31:0] imem [Depth];
  logic [31:0] word;
  logic [31:0] target;

  always_comb begin
    word   = imem[pc_q[ADDR_W+1:2]];
    target = bus.branch_target & ~32'h3;
  end

  // No reset on the array; a same-edge write is only seen by later fetches.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      if_pc_q  <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 16'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
          end
        end
        StRun, StHalt: begin
          if (bus.branch_taken) begin
            state_q  <= StRun;
            pc_q     <= target;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
          end else if (!bus.stall && state_q == StRun) begin
            if (word == HALT_WORD) begin
              state_q  <= StHalt;
              instr_q  <= NOP_WORD;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              instr_q <= word;
              if_pc_q <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + 32'd4;
              if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.if_instr  = instr_q;
    bus.if_pc     = if_pc_q;
    bus.if_valid  = valid_q;
    bus.if_wr     = ~bus.stall & (state_q != StIdle);
    bus.pc        = pc_q;
    bus.halted    = halted_q;
    bus.fetch_cnt = cnt_q;
  end
endmodule
